// File: rtl/router_pkt_tx.sv
// Buffers one packet's payload, then sends header, payload and an XOR parity byte to the router, holding the byte while busy.
// Build option ROUTER_PKT_TX_ERR_INJ_EN: packets latched with err_inj=1 send parity with bit 0 inverted.
module router_pkt_tx (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [1:0] addr,
  input  logic [5:0] payload_len,
  input  logic       err_inj,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic       busy,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       tx_active,
  output logic       done,
  output logic       bad_req
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] HDR  = 3'd2;
  localparam logic [2:0] PAY  = 3'd3;
  localparam logic [2:0] PAR  = 3'd4;

  logic [2:0] state;
  logic [1:0] addr_q;
  logic [5:0] len_q;
  logic [5:0] wr_cnt;
  logic [5:0] rd_cnt;
  logic [7:0] acc;
  logic [7:0] mem [64];
  logic [7:0] hdr;
  logic [7:0] par_byte;
  logic [5:0] last_idx;

  assign hdr      = {len_q, addr_q};
  assign last_idx = len_q - 6'd1;

`ifdef ROUTER_PKT_TX_ERR_INJ_EN
  logic err_q;
  assign par_byte = acc ^ {7'd0, err_q};
`else
  logic unused_err;
  assign unused_err = err_inj;
  assign par_byte   = acc;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      addr_q  <= 2'd0;
      len_q   <= 6'd0;
      wr_cnt  <= 6'd0;
      rd_cnt  <= 6'd0;
      acc     <= 8'd0;
      done    <= 1'b0;
      bad_req <= 1'b0;
`ifdef ROUTER_PKT_TX_ERR_INJ_EN
      err_q   <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      bad_req <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (addr == 2'd3 || payload_len == 6'd0) begin
              bad_req <= 1'b1;
            end else begin
              addr_q <= addr;
              len_q  <= payload_len;
              acc    <= 8'd0;
              wr_cnt <= 6'd0;
              rd_cnt <= 6'd0;
`ifdef ROUTER_PKT_TX_ERR_INJ_EN
              err_q  <= err_inj;
`endif
              state  <= LOAD;
            end
          end
        end
        LOAD: begin
          if (pl_valid) begin
            acc    <= acc ^ pl_data;
            wr_cnt <= wr_cnt + 6'd1;
            if (wr_cnt == last_idx) state <= HDR;
          end
        end
        HDR: begin
          if (!busy) begin
            acc   <= acc ^ hdr;
            state <= PAY;
          end
        end
        PAY: begin
          if (!busy) begin
            rd_cnt <= rd_cnt + 6'd1;
            if (rd_cnt == last_idx) state <= PAR;
          end
        end
        PAR: begin
          if (!busy) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Payload storage is never reset; a new packet always overwrites before reading.
  always_ff @(posedge clock) begin
    if (state == LOAD && pl_valid) mem[wr_cnt] <= pl_data;
  end

  // Outputs decode from registered state only, so busy never reaches them combinationally.
  always_comb begin
    data_out = 8'd0;
    case (state)
      HDR:     data_out = hdr;
      PAY:     data_out = mem[rd_cnt];
      PAR:     data_out = par_byte;
      default: data_out = 8'd0;
    endcase
  end

  assign pkt_valid = (state == HDR) || (state == PAY);
  assign pl_ready  = (state == LOAD);
  assign tx_active = (state != IDLE);

endmodule

// File: doc/router_pkt_tx.md
ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: resetn  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: start  input  1  request to send one packet; sampled in IDLE only.
REQ-004 SHALL have port: addr  input  2  destination port 0..2; 3 is illegal.
REQ-005 SHALL have port: payload_len  input  6  payload byte count 1..63; 0 is illegal.
REQ-006 SHALL have port: err_inj  input  1  corrupt parity of this packet; sampled with start.
REQ-007 SHALL have port: pl_data  input  8  payload byte from the upstream source.
REQ-008 SHALL have port: pl_valid  input  1  pl_data is valid.
REQ-009 SHALL have port: pl_ready  output  1  block accepts pl_data this cycle.
REQ-010 SHALL have port: busy  input  1  router stall; the presented byte must be held.
REQ-011 SHALL have port: pkt_valid  output  1  high on header and payload bytes, low on parity byte.
REQ-012 SHALL have port: data_out  output  8  byte presented to the router.
REQ-013 SHALL have port: tx_active  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port: done  output  1  one-cycle pulse after the parity byte transfers.
REQ-015 SHALL have port: bad_req  output  1  one-cycle pulse when start is rejected.

Function
REQ-016 SHALL use states IDLE, LOAD, HDR, PAY and PAR.
REQ-017 In IDLE with start=1, SHALL test addr and payload_len: if addr=3 or payload_len=0, pulse bad_req and stay in IDLE; otherwise latch addr, payload_len and err_inj, clear the parity accumulator and the counters, and go to LOAD.
REQ-018 In LOAD, pl_ready SHALL be 1; each edge with pl_valid&pl_ready SHALL write pl_data into a 64x8 buffer at wr_cnt, XOR it into the accumulator and increment wr_cnt.
REQ-019 SHALL go from LOAD to HDR on the edge that accepts byte payload_len-1; pl_ready SHALL be 0 in every other state.
REQ-020 A transfer SHALL occur on any rising edge in HDR, PAY or PAR with busy=0; with busy=1, data_out and pkt_valid SHALL hold unchanged.
REQ-021 HDR SHALL present data_out={payload_len,addr} with pkt_valid=1; on transfer, XOR the header into the accumulator and go to PAY.
REQ-022 PAY SHALL present buffer[rd_cnt] with pkt_valid=1; each transfer increments rd_cnt, and the transfer of byte payload_len-1 goes to PAR.
REQ-023 PAR SHALL present the accumulator (XOR of the header and all payload bytes) with pkt_valid=0; on transfer, pulse done and go to IDLE.
REQ-024 data_out and pkt_valid SHALL be registered or decoded from state only, with no combinational path from busy, pl_valid or start.
REQ-025 In IDLE, data_out SHALL be 0 and pkt_valid SHALL be 0.
REQ-026 The packet SHALL have no bubble: pkt_valid stays high continuously from HDR through the last PAY byte.
REQ-027 start outside IDLE SHALL be ignored, with no bad_req pulse.
REQ-028 Back-to-back packets SHALL be allowed: start may be accepted on the cycle after the done pulse.

Reset
REQ-029 resetn=0 SHALL immediately force state IDLE, and pkt_valid, data_out, pl_ready, tx_active, done, bad_req, the counters and the accumulator to 0.
REQ-030 Reset mid-packet SHALL abandon the packet; buffer contents need no reset and SHALL NOT be reused.

Configuration
REQ-031 With macro ROUTER_PKT_TX_ERR_INJ_EN defined, a packet latched with err_inj=1 SHALL send the parity byte with bit 0 inverted.
REQ-032 Without ROUTER_PKT_TX_ERR_INJ_EN, the err_inj port SHALL remain present but be ignored, and parity SHALL always be correct.

Verification
REQ-033 addr=1, len=3, payload 0x11,0x22,0x33, busy=0 -> data_out 0x0D,0x11,0x22,0x33 with pkt_valid=1, then 0x0D with pkt_valid=0, then done for 1 cycle.
REQ-034 Same packet with busy=1 for 3 cycles while 0x22 is presented -> 0x22 held for 4 cycles, sequence otherwise unchanged, no byte lost or duplicated.
REQ-035 start with addr=3, or with len=0 -> bad_req pulses for 1 cycle, tx_active stays 0, pl_ready stays 0.
REQ-036 addr=2, len=63, all bytes 0xFF, pl_valid toggled every other cycle -> 63 bytes loaded, header 0xFE, parity 0x01, no pkt_valid gap.
REQ-037 resetn low during PAY -> pkt_valid and data_out go to 0 without waiting for a clock edge; the next start sends a fresh, correct packet.
REQ-038 With ROUTER_PKT_TX_ERR_INJ_EN defined, packet of REQ-033 sent with err_inj=1 -> parity byte 0x0C; without the macro -> parity byte 0x0D.
